// File: rtl/seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, branch condition codes, PC step.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   localparam logic [4:0] COND_NC = 5'd0;
   localparam logic [4:0] COND_C  = 5'd1;
   localparam logic [4:0] COND_S  = 5'd2;
   localparam logic [4:0] COND_AL = 5'd3;
   localparam logic [4:0] COND_Z  = 5'd4;
   localparam logic [4:0] COND_NZ = 5'd5;

   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_resolve.sv
// Branch resolution: sequential PC, branch target and taken decision from condition code and ALU flags.
// Purely combinational, zero latency; no flow control.
module branch_resolve
   import seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        branch,
   input  logic        branch_src,
   input  logic [4:0]  fcode,
   input  logic [31:0] label,
   input  logic [31:0] read_data1,
   input  logic        sign,
   input  logic        zero,
   input  logic        carry,
   output logic [31:0] seq,
   output logic [31:0] target,
   output logic        take
);

   logic cond;

   always_comb begin
      cond = 1'b0;
      case (fcode)
         COND_NC: cond = ~carry;
         COND_C:  cond = carry;
         COND_S:  cond = sign;
         COND_AL: cond = 1'b1;
         COND_Z:  cond = zero;
         COND_NZ: cond = ~zero;
         default: cond = 1'b0;
      endcase
   end

   // Offsets add modulo 2^32, so two's-complement offsets branch backwards.
   assign seq    = pc + PC_STEP;
   assign target = seq + (branch_src ? label : read_data1);
   assign take   = branch & cond;

endmodule

// File: rtl/pc_sequencer.sv
// PC controller: IDLE -> FETCH (imem_req until imem_ack) -> EXEC (wait exec_done, resolve next PC).
// Min 2 cycles/instr; fetch stalls on imem_ack, resolve stalls on exec_done. BRANCH_COUNT_EN adds taken_count.
module pc_sequencer
   import seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        branch,
   input  logic        branch_src,
   input  logic [4:0]  fcode,
   input  logic [31:0] label,
   input  logic [31:0] read_data1,
   input  logic        sign,
   input  logic        zero,
   input  logic        carry,
   input  logic        link,
   output logic [31:0] pc,
   output logic        link_we,
   output logic [31:0] link_data,
   output logic        taken,
   output logic        busy
`ifdef BRANCH_COUNT_EN
   ,
   input  logic        count_clr,
   output logic [15:0] taken_count
`endif
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        taken_q, taken_d;
   logic        halt_pend_q, halt_pend_d;
   logic        instr_valid_q, instr_valid_d;
   logic        resolve;

   logic [31:0] seq;
   logic [31:0] target;
   logic        take;

   branch_resolve u_resolve (
      .pc         (pc_q),
      .branch     (branch),
      .branch_src (branch_src),
      .fcode      (fcode),
      .label      (label),
      .read_data1 (read_data1),
      .sign       (sign),
      .zero       (zero),
      .carry      (carry),
      .seq        (seq),
      .target     (target),
      .take       (take)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      taken_d       = taken_q;
      halt_pend_d   = halt_pend_q;
      instr_valid_d = 1'b0;
      resolve       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = FETCH;
         end
         FETCH: begin
            // A coincident halt loses to the ack: the fetched instruction still completes.
            if (imem_ack) begin
               state_d       = EXEC;
               instr_valid_d = 1'b1;
            end else if (halt) begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (halt) halt_pend_d = 1'b1;
            if (exec_done) begin
               resolve = 1'b1;
               pc_d    = take ? target : seq;
               taken_d = take;
               state_d = (halt || halt_pend_q) ? IDLE : FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) halt_pend_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         taken_q       <= 1'b0;
         halt_pend_q   <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         taken_q       <= taken_d;
         halt_pend_q   <= halt_pend_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign link_we     = resolve & link;
   assign link_data   = link_we ? seq : 32'd0;
   assign taken       = taken_q;
   assign busy        = (state_q != IDLE);

`ifdef BRANCH_COUNT_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (count_clr) begin
         count_d = 16'd0;
      end else if (resolve && take && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= 16'd0;
      else     count_q <= count_d;
   end

   assign taken_count = count_q;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter controller that sequences the branch-resolution datapath of the single-issue core. It owns the PC register and handshakes instruction fetch with instruction memory. It waits for the execute stage to finish, then resolves the next PC from the branch controls and ALU flags. It also produces the link-register write (PC+4) for call instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin fetching from current PC; honored only in IDLE
- halt  in  1  stop at next instruction boundary
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address, equals pc while imem_req=1
- imem_ack  in  1  fetch complete; sampled only while imem_req=1
- instr_valid  out  1  one-cycle pulse: fetched instruction is ready for decode/execute
- exec_done  in  1  execute stage finished; branch controls and flags valid this cycle
- branch  in  1  instruction is a branch
- branch_src  in  1  1: offset=label; 0: offset=read_data1
- fcode  in  5  branch condition code
- label  in  32  immediate branch offset
- read_data1  in  32  register branch offset
- sign, zero, carry  in  1 each  ALU flags
- link  in  1  instruction writes link register
- pc  out  32  current PC
- link_we  out  1  one-cycle link write strobe
- link_data  out  32  PC+4 of the completing instruction
- taken  out  1  registered: last resolved branch was taken
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: start=1 → FETCH. All other inputs are ignored.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ack=1 → EXEC, and instr_valid pulses in the first EXEC cycle.
  - halt=1 with imem_ack=0 → IDLE, and imem_req drops.
  - halt and imem_ack in the same cycle: ack wins and the instruction completes.
- EXEC: waits for exec_done. On exec_done:
  - seq = pc+4.
  - target = seq + (branch_src ? label : read_data1).
  - cond by fcode: 0 = ~carry, 1 = carry, 2 = sign, 3 = always, 4 = zero, 5 = ~zero, 6–31 = never.
  - take = branch & cond.
  - pc ← take ? target : seq.
  - taken ← take.
  - link=1 → link_we=1 and link_data=seq in that same cycle, combinational from the current pc.
  - Next state: halt=1 (or latched halt) → IDLE, else FETCH.
- halt is latched (halt_pend) in EXEC and cleared on entering IDLE.
- Arithmetic: 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 = 0. Offsets are added unsigned, so two's-complement offsets give backward branches.
- Only instruction completion modifies pc. An abandoned fetch leaves pc unchanged.

## Timing
- Reset values: state = IDLE, pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, link_we = 0, link_data = 0, taken = 0, busy = 0.
- Reset mid-operation aborts immediately (asynchronous). There is no pending write.
- start → imem_req=1 in the next cycle.
- imem_ack at edge N → instr_valid high in cycle N+1.
- exec_done at edge M → new pc visible in cycle M+1, with imem_req=1 for the new pc.
- Minimum 2 cycles per instruction (ack and exec_done each on their first eligible cycle).
- exec_done outside EXEC and imem_ack outside FETCH are ignored.

## Configuration
- BRANCH_COUNT_EN defined:
  - adds output taken_count (16 bits), reset 0, incremented on each exec_done with take=1;
  - saturates at 16'hFFFF;
  - adds input count_clr, a synchronous clear with priority over increment.
- BRANCH_COUNT_EN undefined: the port, counter and clear logic are absent.

## Structure
- Package seq_pkg:
  - state enum (IDLE, FETCH, EXEC);
  - condition-code constants COND_NC=0, COND_C=1, COND_S=2, COND_AL=3, COND_Z=4, COND_NZ=5;
  - PC_STEP=32'd4.
- Sub-module branch_resolve: combinational. Inputs pc, branch, branch_src, fcode, label, read_data1, flags. Outputs seq, target, take.

## Test plan
- Reset with RESET_PC=32'h100, then start, ack immediately, exec_done with branch=0 → pc=32'h104, imem_addr=32'h104, taken=0.
- pc=32'h200, branch=1, fcode=4, zero=1, branch_src=1, label=32'h10 → pc=32'h214, taken=1. Repeat with zero=0 → pc=32'h204.
- pc=32'h40, branch=1, fcode=3, branch_src=0, read_data1=32'hFFFF_FFF0 (−16) → pc=32'h34. link=1 → link_we pulse with link_data=32'h44.
- pc=32'hFFFF_FFFC, branch=0 → pc=0. fcode=7 with branch=1 → not taken.
- halt asserted in FETCH with ack withheld → imem_req drops next cycle, IDLE, pc unchanged. halt in EXEC → completes, then IDLE. rst asserted mid-EXEC → all outputs at reset values asynchronously.
- BRANCH_COUNT_EN: 3 taken and 2 not-taken branches → taken_count=3. count_clr coinciding with a taken branch → 0.
